// File: rtl/serial_demux.sv
// Serial-to-parallel demux: steers accepted bits into slot sel and presents each full word on a valid/ready output.
// Optional build macro SERIAL_DEMUX_MSB_FIRST_EN reverses the fill order (first bit lands in bit WIDTH-1).
module serial_demux #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err
);

    // state | meaning
    // IDLE  | sel=0, no partial frame
    // FILL  | partial frame held in shadow
    // STALL | last bit of a frame waiting for the consumer to free the output
    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_frame_err;

    logic               w_last;
    logic               w_accept;
    logic               w_complete;
    logic [SEL_W-1:0]   w_slot;
    logic [SEL_W-1:0]   w_sof_slot;
    logic [WIDTH-1:0]   w_fill;
    logic [WIDTH-1:0]   w_sof_word;

    assign w_last     = (r_sel == SEL_W'(WIDTH - 1));
    assign in_ready   = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && !in_sof && w_last;

`ifdef SERIAL_DEMUX_MSB_FIRST_EN
    assign w_slot     = ~r_sel;
    assign w_sof_slot = SEL_W'(WIDTH - 1);
`else
    assign w_slot     = r_sel;
    assign w_sof_slot = '0;
`endif

    // Slot update merged combinationally so a completing bit goes straight to out_data.
    always_comb begin
        w_fill             = r_shadow;
        w_fill[w_slot]     = in_bit;
        w_sof_word         = '0;
        w_sof_word[w_sof_slot] = in_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_shadow    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_accept) begin
                if (in_sof) begin
                    r_shadow    <= w_sof_word;
                    r_sel       <= SEL_W'(1);
                    r_frame_err <= (r_sel != '0);
                    r_state     <= FILL;
                end else begin
                    r_shadow <= w_fill;
                    r_sel    <= r_sel + SEL_W'(1);
                    if (w_last) begin
                        r_out_data <= w_fill;
                        r_state    <= IDLE;
                    end else begin
                        r_state    <= FILL;
                    end
                end
            end else if (in_valid) begin
                r_state <= STALL;
            end else if (r_state == STALL && out_ready) begin
                r_state <= FILL;
            end

            if (w_complete) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_demux.sv
// Directed, table-driven bench for serial_demux (LSB-first or SERIAL_DEMUX_MSB_FIRST_EN build).
`timescale 1ns/1ps
module tb_serial_demux;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             frame_err;

    always #5 clk = ~clk;

    serial_demux #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    typedef struct {
        logic       b;
        logic       v;
        logic       s;
        logic       r;
        logic       e_rdy;
        logic [2:0] e_sel;
        logic       e_ov;
        logic [7:0] e_data;
        logic       e_ferr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    // Expected word as seen on out_data, given the word in LSB-first bit order.
    function automatic logic [7:0] ord(input logic [7:0] w);
        logic [7:0] r;
`ifdef SERIAL_DEMUX_MSB_FIRST_EN
        for (int k = 0; k < 8; k++) r[k] = w[7-k];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic add(input logic b, input logic v, input logic s, input logic r,
                       input logic e_rdy, input int e_sel, input logic e_ov,
                       input logic [7:0] e_data, input logic e_ferr);
        vec_t x;
        x.b = b; x.v = v; x.s = s; x.r = r;
        x.e_rdy = e_rdy; x.e_sel = 3'(e_sel); x.e_ov = e_ov;
        x.e_data = e_data; x.e_ferr = e_ferr;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            in_bit = tbl[i].b; in_valid = tbl[i].v; in_sof = tbl[i].s; out_ready = tbl[i].r;
            #1;
            chk($sformatf("%s[%0d].in_ready", tag, i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].sel", tag, i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("%s[%0d].out_data", tag, i), 32'(out_data), 32'(tbl[i].e_data));
            chk($sformatf("%s[%0d].frame_err", tag, i), 32'(frame_err), 32'(tbl[i].e_ferr));
        end
        tbl.delete();
        @(negedge clk);
        in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] prev;
        logic [7:0] ws [2];

        #12;
        chk("reset.sel", 32'(sel), 0);
        chk("reset.out_valid", 32'(out_valid), 0);
        chk("reset.out_data", 32'(out_data), 0);
        chk("reset.frame_err", 32'(frame_err), 0);
        chk("reset.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic word A5, then 03 and A5 back-to-back with out_ready=1.
        w = 8'hA5;
        for (int i = 0; i < 8; i++)
            add(w[i], 1, 0, 1, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : 8'h00, 0);
        add(0, 0, 0, 1, 1, 0, 0, ord(8'hA5), 0);
        ws[0] = 8'h03; ws[1] = 8'hA5;
        prev = 8'hA5;
        for (int j = 0; j < 2; j++) begin
            w = ws[j];
            for (int i = 0; i < 8; i++)
                add(w[i], 1, 0, 1, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : ord(prev), 0);
            prev = w;
        end
        add(0, 0, 0, 1, 1, 0, 0, ord(8'hA5), 0);

        // Backpressure: 3C held, FF stalls at sel=7, released with coincident completion.
        w = 8'h3C;
        for (int i = 0; i < 8; i++)
            add(w[i], 1, 0, 0, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : ord(8'hA5), 0);
        for (int i = 0; i < 7; i++)
            add(1, 1, 0, 0, 1, i + 1, 1, ord(8'h3C), 0);
        add(1, 1, 0, 0, 0, 7, 1, ord(8'h3C), 0);
        add(1, 1, 0, 0, 0, 7, 1, ord(8'h3C), 0);
        add(1, 1, 0, 1, 1, 0, 1, ord(8'hFF), 0);
        add(0, 0, 0, 1, 1, 0, 0, ord(8'hFF), 0);

        // Resync: 3 bits, ignored sof without valid, sof mid-frame, then 7 zeros.
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 1, 1, i + 1, 0, ord(8'hFF), 0);
        add(0, 0, 1, 1, 1, 3, 0, ord(8'hFF), 0);
        add(1, 1, 1, 1, 1, 1, 0, ord(8'hFF), 1);
        for (int i = 1; i < 8; i++)
            add(0, 1, 0, 1, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(8'h01) : ord(8'hFF), 0);

        // sof at sel=0 (no error) then 96 with idle gaps between bits.
        w = 8'h96;
        add(w[0], 1, 1, 1, 1, 1, 0, ord(8'h01), 0);
        for (int i = 1; i < 8; i++) begin
            add(1, 0, 0, 1, 1, i, 0, ord(8'h01), 0);
            add(w[i], 1, 0, 1, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : ord(8'h01), 0);
        end
        add(0, 0, 0, 1, 1, 0, 0, ord(8'h96), 0);
        run_tbl("main");

        // Reach sel=5 with a word pending, then reset between clock edges.
        w = 8'h5A;
        for (int i = 0; i < 8; i++)
            add(w[i], 1, 0, 0, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : ord(8'h96), 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 1, i + 1, 1, ord(8'h5A), 0);
        run_tbl("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.sel", 32'(sel), 0);
        chk("async_rst.out_valid", 32'(out_valid), 0);
        chk("async_rst.out_data", 32'(out_data), 0);
        chk("async_rst.in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        w = 8'hC3;
        for (int i = 0; i < 8; i++)
            add(w[i], 1, 0, 1, 1, (i + 1) % 8, i == 7, (i == 7) ? ord(w) : 8'h00, 0);
        add(0, 0, 0, 1, 1, 0, 0, ord(8'hC3), 0);
        run_tbl("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_demux.md
Name: serial_demux

Overview:
- Sequential 1-to-WIDTH demultiplexer and deserializer; the receive-side counterpart of the team's WIDTH:1 bit-select mux.
- Each accepted serial bit is steered into the slot chosen by an internal select counter.
- When all WIDTH slots are filled, the assembled word is presented on a valid/ready parallel output.
- Sits between a serial link (or a mux driven by a free-running select) and word-wide consumers.

Parameters:
WIDTH, 8, parallel word width; must be a power of two, at least 2.
SEL_W, 3, select/index width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is valid this cycle
in_sof  input  1  start-of-frame; qualified by in_valid; forces this bit into slot 0
in_ready  output  1  block can accept in_bit this cycle
sel  output  SEL_W  slot index the next accepted bit will occupy
out_data  output  WIDTH  assembled parallel word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data
frame_err  output  1  one-cycle pulse: in_sof arrived with a partial frame pending

Behaviour:
- Reset is asynchronous and active-low; all state is registered on the rising edge of clk. While rst_n=0:
  - sel=0, shadow register=0, out_data=0, out_valid=0, frame_err=0, FSM=IDLE.
  - in_ready=1 (combinational from state).
- Accept: a bit is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: sel=0, no partial frame.
  - FILL: 0 < sel ≤ WIDTH-1, partial frame held.
  - STALL: frame's last bit waiting because out_valid=1 && !out_ready.
- Transitions:
  - IDLE -> FILL on accept.
  - FILL -> IDLE on accepting the bit at sel=WIDTH-1; that completes the word.
  - FILL -> STALL when sel=WIDTH-1 && in_valid && out_valid && !out_ready.
  - STALL -> FILL when out_ready=1 (same combinational cycle; see in_ready).
- in_ready = !(sel==WIDTH-1 && out_valid && !out_ready). Bits at sel<WIDTH-1 are always accepted, even while a previous word awaits the consumer (single-word double buffering via shadow).
- On accept: shadow[sel] <= in_bit; sel <= sel+1, wrapping modulo WIDTH.
- Completion (accept at sel=WIDTH-1):
  - Next cycle: out_data = shadow with bit WIDTH-1 = in_bit; out_valid=1; sel=0.
  - Latency: out_valid rises 1 cycle after the WIDTH-th accepted bit.
- out_valid clears on a cycle with out_ready=1 and no completion. If completion and out_ready coincide, the new word loads and out_valid stays 1.
- out_data holds its value until the next completion, including after being consumed.
- in_sof with accept:
  - Bit is written to slot 0; sel <= 1; remaining shadow bits are cleared to 0.
  - If sel≠0 at that time, frame_err=1 for one cycle and the partial frame is discarded.
  - in_sof at sel=0: no error.
  - in_sof without in_valid is ignored.
  - WIDTH=2 edge: in_sof never completes a word by itself.
- No accept: sel, shadow, and FSM state hold.
- Reset mid-frame: partial frame and any pending output are discarded; out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: SERIAL_DEMUX_MSB_FIRST_EN.
- Defined: fill order is reversed; slot = WIDTH-1-sel, so the first accepted bit lands in bit WIDTH-1. in_sof targets bit WIDTH-1. The sel port still counts 0..WIDTH-1.
- Undefined: LSB-first; slot = sel.
- Handshake, latency, and error behaviour are identical in both builds.

Test Plan:
- Basic word: reset, out_ready=1, in_valid=1 on 8 consecutive cycles with bits 1,0,1,0,0,1,0,1 -> out_data=8'hA5, out_valid=1 for exactly one cycle, 1 cycle after the 8th bit; sel back to 0. With SERIAL_DEMUX_MSB_FIRST_EN defined -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome), so also send 1,1,0,0,0,0,0,0 -> 8'hC0 (MSB-first) vs 8'h03 (LSB-first).
- Backpressure: out_ready=0, send 16 bits (8'h3C then 8'hFF) -> first word held, in_ready=0 at sel=7 of the second frame; raise out_ready -> 8'h3C consumed, 8'hFF appears next cycle, no bit lost.
- Back-to-back with out_ready=1 and continuous in_valid -> one word every 8 cycles, out_valid pulses with no gaps or duplicates.
- Resync: send 3 bits, then in_sof=1 with bit 1, then 7 bits 0 -> frame_err pulse 1 cycle, out_data=8'h01.
- Async reset: assert rst_n=0 mid-cycle at sel=5 while out_valid=1 -> out_valid, out_data, sel=0 immediately without a clock edge; the first frame after release decodes correctly.
- Idle gaps: in_valid toggling 1/0 across a frame of 8'h96 -> sel advances only on accepted bits; out_data=8'h96.
